farrow_timing_ctrl: RTL and testbench
=====================================

Name: farrow_timing_ctrl

Overview:
- Interpolation controller (modulo-1 NCO) that generates the fractional-delay control `mu` for the farrow interpolator. It is the control side of the farrow `enable_in` / `mu_in` / `data_in` interface.
- Per input sample, the NCO decrements by a step W. Each underflow marks a symbol instant; at that instant `mu` = eta/W is computed through a reciprocal multiply.
- Data, enable, strobe and mu leave time-aligned. They connect directly to the farrow inputs and the downstream symbol decimator. Sits between the ADC sample stream and the farrow; the timing-loop filter drives `adj_in`.

Parameters:
- DW, 16, data path width in bits (data_in / data_out).
- ETA_RST, 16383, NCO register value after reset (Q1.14, just below 1.0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- sample_valid  in  1  data_in carries a new sample this cycle.
- data_in  in  DW  signed input sample.
- step_in  in  16  nominal NCO step W, unsigned Q2.14; legal range 1..16384.
- inv_step_in  in  16  reciprocal 1/W, unsigned Q4.12.
- adj_in  in  16  signed loop correction, Q2.14.
- adj_valid  in  1  load adj_in into the correction register.
- data_out  out  DW  data_in delayed by 2 cycles.
- enable_out  out  1  sample_valid delayed by 2 cycles; drives farrow `enable_in`.
- mu_out  out  16  signed Q2.14 fractional offset, range 0..16383; drives farrow `mu_in`.
- strobe_out  out  1  this output sample is a symbol interpolation instant.

Behaviour:
- Reset (synchronous, reset high at a clock edge):
  - eta=ETA_RST, adj_reg=0, all pipeline registers cleared.
  - data_out=0, enable_out=0, mu_out=0, strobe_out=0.
  - Reset mid-operation discards in-flight samples; nothing is emitted for them.
- Correction register:
  - On adj_valid, adj_reg<=adj_in. The value is held until the next adj_valid.
  - A sample arriving in the same cycle as adj_valid uses the old adj_reg. The new value applies from the next sample.
- Effective step:
  - w_eff = step_in + adj_reg, computed at 18-bit signed width.
  - w_eff is clamped to 1..16384; 0 and negative values clamp to 1.
- NCO update, only on cycles with sample_valid=1:
  - d = eta - w_eff, 17-bit signed.
  - If d >= 0: eta<=d, strobe=0.
  - If d < 0 (underflow): eta<=d+16384, strobe=1, and the pre-decrement eta is captured for the mu calculation.
  - d = 0 exactly is not an underflow.
  - With sample_valid=0, eta and adj usage are frozen.
- Pipeline, exactly 2 cycles from sample_valid/data_in to outputs:
  - Stage 1 registers: valid, data, strobe, eta_cap, inv_step.
  - Stage 2 computes prod = eta_cap(15b) * inv_step(16b) = 31-bit unsigned, then m = prod>>12.
  - mu = min(m, 16383).
  - Stage 2 registers all outputs.
- mu_out and strobe_out:
  - mu_out updates only when the stage-2 valid and strobe are both 1; otherwise it holds its last value.
  - strobe_out is 1 only when enable_out=1.
- Bubbles:
  - sample_valid=0 propagates as enable_out=0 and strobe_out=0.
  - data_out still shifts every cycle.
- inv_step_in is sampled at the same edge as the underflowing sample. It is the host's responsibility to keep it consistent with w_eff; mismatch only affects mu accuracy, and saturation still guarantees mu <= 16383.
- No combinational path from any input to any output.

Test Plan:
- reset 2 cycles, step=8192, inv=8192 (2.0), adj=0, continuous valid:
  - eta sequence 8191, 16383, 8191, ...
  - strobe_out on every 2nd enable_out, first at cycle 4 after reset release.
  - mu_out=16382 on every strobe.
  - data_out equals data_in delayed by exactly 2 cycles.
- step=6554, inv=10240 (2.5), continuous valid from reset:
  - eta 9829, 3275, then underflow to 13105 with strobe.
  - mu_out = 3275*2.5 -> 8187.
- step=16384, inv=4096:
  - strobe on every sample, mu_out=16383.
  - then adj_valid with adj_in=+100: w_eff stays clamped at 16384, behaviour unchanged.
  - adj_in=-20000: w_eff clamps to 1, no strobe for about 16383 samples.
- step=8192, inv=16384:
  - raw m = 8191*4 = 32764, mu_out saturates to 16383.
- sample_valid toggling 1,0,1,0 with step=8192:
  - eta changes only on valid cycles.
  - enable_out mirrors valid 2 cycles later.
  - strobe on every 2nd valid sample; mu_out holds between strobes.
- reset asserted for 1 cycle mid-stream, with adj_valid in the same cycle as an underflowing sample:
  - all outputs 0 the cycle after reset.
  - eta restarts at 16383 and the old adj_reg is cleared.
  - the same-cycle adj_valid applies only from the following sample (checked separately, before the reset).

Source files
------------

// File: rtl/farrow_timing_ctrl.sv
`timescale 1ns/1ps
// farrow_timing_ctrl: modulo-1 NCO interpolation controller for the farrow
// interpolator. Per valid sample the NCO is decremented by the effective step.
// Each underflow marks a symbol instant, where mu = eta * (1/W) is produced.
// Data, enable, strobe and mu leave the block time-aligned, two cycles after input.
module farrow_timing_ctrl #(
  parameter int unsigned DW      = 16,
  parameter int unsigned ETA_RST = 16383
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic [DW-1:0] data_in,
  input  logic [15:0]   step_in,
  input  logic [15:0]   inv_step_in,
  input  logic [15:0]   adj_in,
  input  logic          adj_valid,
  output logic [DW-1:0] data_out,
  output logic          enable_out,
  output logic [15:0]   mu_out,
  output logic          strobe_out
);

  localparam logic [14:0] ETA_INIT = 15'(ETA_RST);

  logic signed [15:0] adj_q;
  logic [14:0]        eta_q, eta_d;
  logic signed [17:0] w_sum;
  logic [16:0]        w_eff;
  logic signed [16:0] d;
  logic               underflow;

  logic               v1_q, stb1_q;
  logic [DW-1:0]      data1_q;
  logic [14:0]        cap1_q;
  logic [15:0]        inv1_q;

  logic [30:0]        prod;
  logic [18:0]        m;
  logic [15:0]        mu_sat;

  // Effective step with clamp to 1..16384, NCO decrement and modulo-1 wrap.
  always_comb begin
    w_sum = $signed({2'b00, step_in}) + $signed({{2{adj_q[15]}}, adj_q});
    if (w_sum < 18'sd1) begin
      w_eff = 17'd1;
    end else if (w_sum > 18'sd16384) begin
      w_eff = 17'd16384;
    end else begin
      w_eff = w_sum[16:0];
    end
    d         = $signed({2'b00, eta_q}) - $signed(w_eff);
    underflow = d[16];
    eta_d     = eta_q;
    if (sample_valid) begin
      eta_d = underflow ? 15'(d + 17'sd16384) : 15'(d);
    end
  end

  // Reciprocal multiply of the captured pre-decrement eta, saturated to Q2.14 < 1.0.
  always_comb begin
    prod   = 31'(cap1_q) * 31'(inv1_q);
    m      = 19'(prod >> 12);
    mu_sat = (m > 19'd16383) ? 16'd16383 : {2'b00, m[13:0]};
  end

  // NCO state and loop-correction register; a same-cycle sample sees the old adj_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      eta_q <= ETA_INIT;
      adj_q <= '0;
    end else begin
      eta_q <= eta_d;
      if (adj_valid) begin
        adj_q <= adj_in;
      end
    end
  end

  // Stage 1: register sample, strobe decision, captured eta and reciprocal.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      stb1_q  <= 1'b0;
      data1_q <= '0;
      cap1_q  <= '0;
      inv1_q  <= '0;
    end else begin
      v1_q    <= sample_valid;
      stb1_q  <= sample_valid & underflow;
      data1_q <= data_in;
      cap1_q  <= eta_q;
      inv1_q  <= inv_step_in;
    end
  end

  // Stage 2: registered outputs; mu only refreshes on a valid strobe, else holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      enable_out <= 1'b0;
      strobe_out <= 1'b0;
      mu_out     <= '0;
    end else begin
      data_out   <= data1_q;
      enable_out <= v1_q;
      strobe_out <= v1_q & stb1_q;
      if (v1_q && stb1_q) begin
        mu_out <= mu_sat;
      end
    end
  end

endmodule

// File: tb/tb_farrow_timing_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for farrow_timing_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares whenever enable_out is high.
module tb_farrow_timing_ctrl;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [15:0]   step_in = '0;
  logic [15:0]   inv_step_in = '0;
  logic [15:0]   adj_in = '0;
  logic          adj_valid = 1'b0;
  logic [DW-1:0] data_out;
  logic          enable_out;
  logic [15:0]   mu_out;
  logic          strobe_out;

  farrow_timing_ctrl #(.DW(DW), .ETA_RST(16383)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .data_in(data_in),
    .step_in(step_in), .inv_step_in(inv_step_in), .adj_in(adj_in), .adj_valid(adj_valid),
    .data_out(data_out), .enable_out(enable_out), .mu_out(mu_out), .strobe_out(strobe_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    bit            stb;
    int            mu;
    int            cyc;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;
  bit started = 0;
  int stb_cnt = 0;
  int last_stb_mu = -1;

  // reference model state
  int m_eta = 16383;
  int m_adj = 0;
  int m_mu  = 0;
  int seq   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One input cycle; inputs are set just after a posedge and sampled at the next one.
  task automatic cycle(input bit v, input bit av, input int adjval);
    exp_t e;
    int w, d, cap;
    longint p;
    sample_valid = v;
    adj_valid    = av;
    adj_in       = 16'(adjval);
    data_in      = 16'(seq * 1237 + 11);
    seq++;
    if (v) begin
      w = int'(step_in) + m_adj;
      if (w < 1) w = 1;
      if (w > 16384) w = 16384;
      d = m_eta - w;
      e.stb = 0;
      if (d < 0) begin
        e.stb = 1;
        cap   = m_eta;
        m_eta = d + 16384;
        p     = (longint'(cap) * longint'(inv_step_in)) >>> 12;
        m_mu  = (p > 16383) ? 16383 : int'(p);
      end else begin
        m_eta = d;
      end
      e.data = data_in;
      e.mu   = m_mu;
      e.cyc  = cyc + 2;
      q.push_back(e);
    end
    if (av) m_adj = $signed(adjval[15:0]);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0);
  endtask

  task automatic drain();
    sample_valid = 1'b0;
    adj_valid    = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Reset for one or more cycles; optionally with a sample and adj load that must be ignored.
  task automatic do_reset(input int n, input bit with_traffic);
    reset        = 1'b1;
    sample_valid = with_traffic;
    adj_valid    = with_traffic;
    adj_in       = 16'hF000;
    repeat (n) @(posedge clk);
    #1;
    reset        = 1'b0;
    sample_valid = 1'b0;
    adj_valid    = 1'b0;
    q.delete();
    m_eta = 16383;
    m_adj = 0;
    m_mu  = 0;
    check("rst_enable", 32'(enable_out), 32'd0);
    check("rst_strobe", 32'(strobe_out), 32'd0);
    check("rst_mu",     32'(mu_out),     32'd0);
    check("rst_data",   32'(data_out),   32'd0);
  endtask

  // Monitor: compare every presented sample against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (enable_out === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'(enable_out), 32'd0);
        end else begin
          e = q.pop_front();
          check("data",    32'(data_out),   32'(e.data));
          check("strobe",  32'(strobe_out), 32'(e.stb));
          check("mu",      32'(mu_out),     32'(e.mu));
          check("latency", 32'(cyc),        32'(e.cyc));
          if (strobe_out === 1'b1) begin
            stb_cnt++;
            last_stb_mu = int'(mu_out);
          end
        end
      end else begin
        check("bubble_strobe", 32'(strobe_out), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    @(posedge clk); #1;
    started = 1;

    // 1: step 0.5, inv 2.0 -> strobe every 2nd sample, mu 16382
    step_in = 16'd8192; inv_step_in = 16'd8192;
    do_reset(2, 1'b0);
    s0 = stb_cnt;
    run(8);
    drain();
    check("t1_strobes", 32'(stb_cnt - s0), 32'd4);
    check("t1_mu", 32'(last_stb_mu), 32'd16382);

    // 2: step 6554, inv 2.5 -> third sample underflows, mu = 3275*2.5 = 8187
    step_in = 16'd6554; inv_step_in = 16'd10240;
    do_reset(1, 1'b0);
    s0 = stb_cnt;
    run(3);
    drain();
    check("t2_strobes", 32'(stb_cnt - s0), 32'd1);
    check("t2_mu", 32'(last_stb_mu), 32'd8187);

    // 3: step 1.0 -> strobe each sample; +100 stays clamped; -20000 clamps to 1
    step_in = 16'd16384; inv_step_in = 16'd4096;
    do_reset(1, 1'b0);
    s0 = stb_cnt;
    run(4);
    cycle(1'b1, 1'b1, 100);
    run(3);
    cycle(1'b1, 1'b1, -20000);
    drain();
    check("t3_strobes", 32'(stb_cnt - s0), 32'd9);
    check("t3_mu", 32'(last_stb_mu), 32'd16383);
    s0 = stb_cnt;
    run(16383);
    drain();
    check("t3_no_strobe_to_zero", 32'(stb_cnt - s0), 32'd0);
    run(1);
    drain();
    check("t3_wrap_strobe", 32'(stb_cnt - s0), 32'd1);
    check("t3_wrap_mu", 32'(last_stb_mu), 32'd0);

    // 4: inv 4.0 -> raw 32764 saturates
    step_in = 16'd8192; inv_step_in = 16'd16384;
    do_reset(1, 1'b0);
    run(2);
    drain();
    check("t4_mu_sat", 32'(last_stb_mu), 32'd16383);

    // 5: alternating valid/bubble, mu holds between strobes
    step_in = 16'd8192; inv_step_in = 16'd8192;
    do_reset(1, 1'b0);
    s0 = stb_cnt;
    for (int i = 0; i < 12; i++) cycle(i[0] == 1'b0, 1'b0, 0);
    drain();
    check("t5_strobes", 32'(stb_cnt - s0), 32'd3);

    // 6: adj loaded with an underflowing sample applies from the next one
    do_reset(1, 1'b0);
    s0 = stb_cnt;
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, -4096);
    run(4);
    drain();
    check("t6_strobes", 32'(stb_cnt - s0), 32'd2);
    check("t6_mu", 32'(last_stb_mu), 32'd8190);

    // 7: mid-stream reset with traffic; adj cleared, eta restarts at 16383
    run(3);
    do_reset(1, 1'b1);
    s0 = stb_cnt;
    run(2);
    drain();
    check("t7_strobes", 32'(stb_cnt - s0), 32'd1);
    check("t7_mu", 32'(last_stb_mu), 32'd16382);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
